// File: rtl/window_match_pkg.sv
// Shared types and the count-vs-target relation for the window match block.
package window_match_pkg;

   // Relation applied at each window boundary (count vs target).
   typedef enum logic [1:0] {
      MODE_EQ = 2'd0,
      MODE_GE = 2'd1,
      MODE_LE = 2'd2,
      MODE_NE = 2'd3
   } mode_e;

   // Control states: waiting for a start, or slicing windows.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Widest count/target the compare has to handle (WIN <= 255).
   localparam int CMP_W = 8;

   // Unsigned compare of a window count against the latched target.
   function automatic logic cmp_match(input logic [CMP_W-1:0] cnt,
                                      input logic [CMP_W-1:0] tgt,
                                      input mode_e            mode);
      logic m;
      m = 1'b0;
      case (mode)
         MODE_EQ: m = (cnt == tgt);
         MODE_GE: m = (cnt >= tgt);
         MODE_LE: m = (cnt <= tgt);
         MODE_NE: m = (cnt != tgt);
         default: m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/window_match_chan.sv
// One channel: ones accumulator, registered window count and match pulse.
module window_match_chan
   import window_match_pkg::*;
#(
   parameter  int WIN = 3,
   localparam int CW  = $clog2(WIN + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          run,
   input  logic          clr,
   input  logic          phase0,
   input  logic          last,
   input  logic          w,
   input  logic [CW-1:0] target_q,
   input  mode_e         mode_q,
   output logic [CW-1:0] count,
   output logic          z
);

   logic [CW-1:0]    acc_q, acc_d;
   logic [CW-1:0]    count_q, count_d;
   logic             z_q, z_d;
   logic [CW-1:0]    sum;
   logic [CMP_W-1:0] sum_w, tgt_w;

   // Accumulate the window; on its last sample register count and match.
   always_comb begin
      sum     = acc_q + CW'(w);
      sum_w   = '0;
      tgt_w   = '0;
      sum_w[CW-1:0] = sum;
      tgt_w[CW-1:0] = target_q;
      acc_d   = '0;
      count_d = count_q;
      z_d     = 1'b0;
      // Phase 0 loads rather than adds so windows run back-to-back.
      if (run && !clr) begin
         acc_d = phase0 ? CW'(w) : sum;
      end
      // A stop on the last sample still lets the full window report.
      if (run && last) begin
         count_d = sum;
         z_d     = cmp_match(sum_w, tgt_w, mode_q);
      end
   end

   // Channel state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q   <= '0;
         count_q <= '0;
         z_q     <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         count_q <= count_d;
         z_q     <= z_d;
      end
   end

   assign count = count_q;
   assign z     = z_q;

endmodule

// File: rtl/window_match_fsm.sv
// Start-triggered windowed ones counter with per-channel relational match.
module window_match_fsm
   import window_match_pkg::*;
#(
   parameter  int WIN = 3,
   parameter  int NCH = 1,
   localparam int CW  = $clog2(WIN + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s,
   input  logic              stop,
   input  logic [NCH-1:0]    w,
   input  logic [CW-1:0]     target,
   input  logic [1:0]        mode,
   output logic [NCH-1:0]    z,
   output logic              win_done,
   output logic [NCH*CW-1:0] count,
   output logic              busy
);

   localparam int PW = $clog2(WIN);

   state_e        state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [CW-1:0] target_q, target_d;
   mode_e         mode_q, mode_d;
   logic          win_done_q, win_done_d;
   logic          busy_q, busy_d;
   logic          run, phase0, last;

   assign run    = (state_q == ST_RUN);
   assign phase0 = (phase_q == '0);
   assign last   = run && (phase_q == PW'(WIN - 1));

   // Next-state, phase counter, start-time latches and window strobe.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      target_d   = target_q;
      mode_d     = mode_q;
      case (state_q)
         ST_IDLE: begin
            phase_d = '0;
            // Start beats a simultaneous stop; target/mode freeze here.
            if (s) begin
               state_d  = ST_RUN;
               target_d = target;
               mode_d   = mode_e'(mode);
            end
         end
         ST_RUN: begin
            phase_d = last ? '0 : phase_q + PW'(1);
            if (stop) begin
               state_d = ST_IDLE;
               phase_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            phase_d = '0;
         end
      endcase
      win_done_d = last;
      busy_d     = (state_d == ST_RUN);
   end

   // Control registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         phase_q    <= '0;
         target_q   <= '0;
         mode_q     <= MODE_EQ;
         win_done_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         target_q   <= target_d;
         mode_q     <= mode_d;
         win_done_q <= win_done_d;
         busy_q     <= busy_d;
      end
   end

   assign win_done = win_done_q;
   assign busy     = busy_q;

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      window_match_chan #(.WIN(WIN)) u_chan (
         .clk      (clk),
         .reset    (reset),
         .run      (run),
         .clr      (stop),
         .phase0   (phase0),
         .last     (last),
         .w        (w[i]),
         .target_q (target_q),
         .mode_q   (mode_q),
         .count    (count[i*CW +: CW]),
         .z        (z[i])
      );
   end

endmodule

// File: tb/tb_window_match_fsm.sv
// Bench for window_match_fsm: three configurations against a sample-counting model.
module tb_window_match_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance 0: WIN=3 NCH=4, instance 1: WIN=4 NCH=1, instance 2: WIN=5 NCH=3.
   logic       rst_i  [3];
   logic       s_i    [3];
   logic       stop_i [3];
   logic [3:0] w_i    [3];
   logic [2:0] tgt_i  [3];
   logic [1:0] mode_i [3];

   logic [3:0] z_a;  logic [7:0] cnt_a; logic wd_a, busy_a;
   logic       z_b;  logic [2:0] cnt_b; logic wd_b, busy_b;
   logic [2:0] z_c;  logic [8:0] cnt_c; logic wd_c, busy_c;

   logic [3:0]  z_o    [3];
   logic [15:0] cnt_o  [3];
   logic        wd_o   [3];
   logic        busy_o [3];

   assign z_o[0] = z_a;            assign cnt_o[0] = {8'b0, cnt_a};
   assign z_o[1] = {3'b0, z_b};    assign cnt_o[1] = {13'b0, cnt_b};
   assign z_o[2] = {1'b0, z_c};    assign cnt_o[2] = {7'b0, cnt_c};
   assign wd_o[0] = wd_a; assign wd_o[1] = wd_b; assign wd_o[2] = wd_c;
   assign busy_o[0] = busy_a; assign busy_o[1] = busy_b; assign busy_o[2] = busy_c;

   window_match_fsm #(.WIN(3), .NCH(4)) dut_a (
      .clk(clk), .reset(rst_i[0]), .s(s_i[0]), .stop(stop_i[0]), .w(w_i[0]),
      .target(tgt_i[0][1:0]), .mode(mode_i[0]), .z(z_a), .win_done(wd_a),
      .count(cnt_a), .busy(busy_a));

   window_match_fsm #(.WIN(4), .NCH(1)) dut_b (
      .clk(clk), .reset(rst_i[1]), .s(s_i[1]), .stop(stop_i[1]), .w(w_i[1][0]),
      .target(tgt_i[1]), .mode(mode_i[1]), .z(z_b), .win_done(wd_b),
      .count(cnt_b), .busy(busy_b));

   window_match_fsm #(.WIN(5), .NCH(3)) dut_c (
      .clk(clk), .reset(rst_i[2]), .s(s_i[2]), .stop(stop_i[2]), .w(w_i[2][2:0]),
      .target(tgt_i[2]), .mode(mode_i[2]), .z(z_c), .win_done(wd_c),
      .count(cnt_c), .busy(busy_c));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   function automatic int win_of(input int k);
      return (k == 0) ? 3 : (k == 1) ? 4 : 5;
   endfunction
   function automatic int nch_of(input int k);
      return (k == 0) ? 4 : (k == 1) ? 1 : 3;
   endfunction
   function automatic int cw_of(input int k);
      return (k == 0) ? 2 : 3;
   endfunction

   function automatic bit rel(input int cnt, input int tgt, input int md);
      case (md)
         0: return cnt == tgt;
         1: return cnt >= tgt;
         2: return cnt <= tgt;
         default: return cnt != tgt;
      endcase
   endfunction

   // Reference model: per instance, a running flag, a sample count and per-channel sums.
   bit          m_run [3];
   int          m_n   [3];
   int          m_sum [3][4];
   int          m_tgt [3];
   int          m_md  [3];
   bit [3:0]    e_z    [3];
   bit [15:0]   e_cnt  [3];
   bit          e_wd   [3];
   bit          e_busy [3];

   // Check outputs against the prediction, then advance the model with the inputs
   // that the coming rising edge will consume (inputs only change just after an edge).
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("z%0d", k),    z_o[k],           16'(e_z[k]));
         chk($sformatf("count%0d", k), cnt_o[k],        e_cnt[k]);
         chk($sformatf("win_done%0d", k), 16'(wd_o[k]), 16'(e_wd[k]));
         chk($sformatf("busy%0d", k), 16'(busy_o[k]),   16'(e_busy[k]));
      end
      for (int k = 0; k < 3; k++) begin
         if (rst_i[k]) begin
            m_run[k] = 0; m_n[k] = 0; m_tgt[k] = 0; m_md[k] = 0;
            for (int c = 0; c < 4; c++) m_sum[k][c] = 0;
            e_z[k] = '0; e_cnt[k] = '0; e_wd[k] = 0; e_busy[k] = 0;
         end else begin
            e_z[k]  = '0;
            e_wd[k] = 0;
            if (!m_run[k]) begin
               if (s_i[k]) begin
                  m_run[k] = 1;
                  m_n[k]   = 0;
                  m_tgt[k] = int'(tgt_i[k]) % (1 << cw_of(k));
                  m_md[k]  = int'(mode_i[k]);
                  for (int c = 0; c < 4; c++) m_sum[k][c] = 0;
               end
            end else begin
               for (int c = 0; c < nch_of(k); c++) m_sum[k][c] += int'(w_i[k][c]);
               m_n[k]++;
               if (m_n[k] == win_of(k)) begin
                  bit [15:0] packed_cnt;
                  bit [3:0]  hits;
                  packed_cnt = '0;
                  hits       = '0;
                  for (int c = 0; c < nch_of(k); c++) begin
                     packed_cnt |= 16'(m_sum[k][c]) << (c * cw_of(k));
                     hits[c] = rel(m_sum[k][c], m_tgt[k], m_md[k]);
                  end
                  e_cnt[k] = packed_cnt;
                  e_z[k]   = hits;
                  e_wd[k]  = 1;
                  m_n[k]   = 0;
                  for (int c = 0; c < 4; c++) m_sum[k][c] = 0;
               end
               if (stop_i[k]) begin
                  m_run[k] = 0;
                  m_n[k]   = 0;
                  for (int c = 0; c < 4; c++) m_sum[k][c] = 0;
               end
            end
            e_busy[k] = m_run[k];
         end
      end
   end

   // Advance one clock; outputs of that edge are readable on return.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_start(input logic [1:0] tgt, input logic [1:0] md);
      s_i[0] = 1'b1; tgt_i[0] = {1'b0, tgt}; mode_i[0] = md;
      step();
      s_i[0] = 1'b0;
   endtask

   task automatic a_samp(input logic [3:0] w, input logic st);
      w_i[0] = w; stop_i[0] = st;
      step();
      w_i[0] = '0; stop_i[0] = 1'b0;
   endtask

   task automatic chk_a(input string nm, input logic [3:0] z, input logic [7:0] cnt,
                        input logic wd, input logic bsy);
      chk({nm, "_z"},    16'(z_a),    16'(z));
      chk({nm, "_cnt"},  16'(cnt_a),  16'(cnt));
      chk({nm, "_wd"},   16'(wd_a),   16'(wd));
      chk({nm, "_busy"}, 16'(busy_a), 16'(bsy));
   endtask

   logic [2:0] b_tgt [5] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd7};
   logic [1:0] b_md  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
   logic       b_z   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst_i[k] = 1'b1; s_i[k] = 1'b0; stop_i[k] = 1'b0;
         w_i[k] = '0; tgt_i[k] = '0; mode_i[k] = '0;
      end
      step();
      step();
      chk_a("reset", 4'h0, 8'h00, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) rst_i[k] = 1'b0;
      step();

      // Legacy alignment: target 2, EQ, channel 0 only.
      a_start(2'd2, 2'd0);
      chk("legacy_busy", 16'(busy_a), 16'd1);
      a_samp(4'h1, 1'b0); a_samp(4'h1, 1'b0); a_samp(4'h0, 1'b0);
      chk_a("legacy_w1", 4'h1, 8'h02, 1'b1, 1'b1);
      a_samp(4'h1, 1'b0); a_samp(4'h0, 1'b0); a_samp(4'h1, 1'b0);
      chk_a("legacy_w2", 4'h1, 8'h02, 1'b1, 1'b1);
      a_samp(4'h1, 1'b0); a_samp(4'h1, 1'b0); a_samp(4'h1, 1'b0);
      chk_a("legacy_w3", 4'h0, 8'h03, 1'b1, 1'b1);
      a_samp(4'h0, 1'b1);
      chk_a("legacy_stop", 4'h0, 8'h03, 1'b0, 1'b0);

      // Four channels, target 1, EQ.
      a_start(2'd1, 2'd0);
      a_samp(4'b0001, 1'b0); a_samp(4'b0011, 1'b0); a_samp(4'b0101, 1'b0);
      chk_a("multi", 4'b0110, 8'h17, 1'b1, 1'b1);

      // Stop mid-window: partial window dropped, count held.
      a_samp(4'hF, 1'b0);
      a_samp(4'hF, 1'b1);
      chk_a("stop_mid", 4'h0, 8'h17, 1'b0, 1'b0);
      step();
      chk_a("stop_mid_idle", 4'h0, 8'h17, 1'b0, 1'b0);

      // Stop on the last sample: window still reports, then idle.
      a_start(2'd3, 2'd1);
      a_samp(4'hF, 1'b0); a_samp(4'h1, 1'b0); a_samp(4'hF, 1'b1);
      chk_a("stop_last", 4'b0001, 8'hAB, 1'b1, 1'b0);
      step();
      chk_a("stop_last_idle", 4'h0, 8'hAB, 1'b0, 1'b0);

      // Restart begins a fresh window at phase 0.
      a_start(2'd0, 2'd0);
      a_samp(4'h0, 1'b0); a_samp(4'h0, 1'b0); a_samp(4'h1, 1'b0);
      chk_a("restart", 4'b1110, 8'h01, 1'b1, 1'b1);
      a_samp(4'h0, 1'b1);

      // s/target/mode changes during RUN are ignored; reset mid-window clears all.
      a_start(2'd1, 2'd0);
      s_i[0] = 1'b1; tgt_i[0] = 3'd3; mode_i[0] = 2'd1;
      a_samp(4'hF, 1'b0); a_samp(4'hF, 1'b0); a_samp(4'hF, 1'b0);
      chk_a("run_ignore", 4'h0, 8'hFF, 1'b1, 1'b1);
      a_samp(4'hF, 1'b0); a_samp(4'hF, 1'b0);
      s_i[0] = 1'b0;
      rst_i[0] = 1'b1; w_i[0] = 4'hF;
      step();
      chk_a("mid_reset", 4'h0, 8'h00, 1'b0, 1'b0);
      rst_i[0] = 1'b0; w_i[0] = '0;
      a_start(2'd3, 2'd0);
      a_samp(4'hF, 1'b0); a_samp(4'hF, 1'b0); a_samp(4'hF, 1'b0);
      chk_a("after_reset", 4'hF, 8'hFF, 1'b1, 1'b1);
      a_samp(4'h0, 1'b1);

      // Relation modes on WIN=4, samples 1,1,1,0 (count 3).
      for (int t = 0; t < 5; t++) begin
         s_i[1] = 1'b1; tgt_i[1] = b_tgt[t]; mode_i[1] = b_md[t];
         step();
         s_i[1] = 1'b0;
         for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 4; j++) begin
               w_i[1] = (j < 3) ? 4'h1 : 4'h0;
               step();
            end
            chk($sformatf("mode%0d_z", t),   16'(z_b),   16'(b_z[t]));
            chk($sformatf("mode%0d_cnt", t), 16'(cnt_b), 16'd3);
            chk($sformatf("mode%0d_wd", t),  16'(wd_b),  16'd1);
         end
         w_i[1] = '0; stop_i[1] = 1'b1;
         step();
         stop_i[1] = 1'b0;
         step();
      end

      // Random traffic on WIN=5, NCH=3; checked every cycle by the model.
      for (int i = 0; i < 2000; i++) begin
         rst_i[2]  = ($urandom_range(0, 199) == 0);
         s_i[2]    = ($urandom_range(0, 7) == 0);
         stop_i[2] = ($urandom_range(0, 15) == 0);
         w_i[2]    = 4'($urandom_range(0, 7));
         tgt_i[2]  = 3'($urandom_range(0, 7));
         mode_i[2] = 2'($urandom_range(0, 3));
         step();
      end
      rst_i[2] = 1'b0; s_i[2] = 1'b0; stop_i[2] = 1'b0; w_i[2] = '0;
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/window_match_fsm.md
Name: window_match_fsm

Overview:
- Parametrised successor to the single-channel start-triggered 3-sample "exactly two ones" detector.
- After a start pulse, the block slices each of NCH serial bit streams into consecutive windows of WIN cycles and counts the ones in each window.
- At each window boundary it compares every channel's count against a runtime target, using a runtime-selected relation, and flags the matches.
- Adds a stop/return-to-idle path, first-window gating (no stale-sum false hit), a count readout and a window-done strobe.

Parameters:
- WIN, 3, samples per window; legal range 2..255.
- NCH, 1, number of independent input channels sharing one window timer.
- CW, $clog2(WIN+1), derived localparam (not overridable): count/target width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- s  in  1  start request; honoured only in IDLE.
- stop  in  1  abort request; honoured only in RUN.
- w  in  NCH  sample bit per channel.
- target  in  CW  compare value; latched on the start cycle.
- mode  in  2  relation, latched on the start cycle: 0 EQ, 1 GE, 2 LE, 3 NE (count vs target).
- z  out  NCH  per-channel match, one-cycle pulse.
- win_done  out  1  one-cycle pulse marking each completed window.
- count  out  NCH*CW  count of the last completed window; channel i sits at [i*CW +: CW].
- busy  out  1  high while in RUN.

Behaviour:
- Reset (synchronous, highest priority):
  - state=IDLE, phase=0, accumulators=0.
  - Latched target/mode=0.
  - z=0, win_done=0, count=0, busy=0.
- IDLE:
  - s=1 moves the block to RUN next cycle and latches target/mode.
  - w is ignored on the s cycle.
  - stop is ignored in IDLE; s wins over a simultaneous stop.
- RUN, every cycle:
  - acc[i] += w[i].
  - phase increments 0..WIN-1 and wraps to 0.
  - The first RUN cycle is phase 0, and acc is loaded with w (not added), so windows are back-to-back with no gap.
- Window completion, on the cycle with phase==WIN-1:
  - Final sum = acc[i]+w[i]. This value is registered into count[i].
  - z[i] is registered as compare(sum, target_q, mode_q).
  - win_done is registered to 1.
  - All three become visible on the next cycle, i.e. the cycle after the last sample, for exactly one cycle.
  - Alignment: with WIN=3, NCH=1, target=2, mode=EQ the z timing is identical to the legacy detector.
  - acc restarts on the next phase 0.
- First-window gating: z and win_done pulse only for fully sampled windows. No pulse occurs on RUN entry.
- Compare is unsigned on CW bits; count never exceeds WIN, so no overflow.
- Out-of-range target (> WIN): EQ and GE never match; LE and NE always match.
- stop in RUN:
  - Next state is IDLE, phase=0, acc=0.
  - A partial window is discarded with no pulse.
  - If stop coincides with phase==WIN-1, the window still completes and pulses next cycle, and the block enters IDLE.
  - count holds its last value in IDLE.
- s during RUN is ignored; the latched target/mode stay fixed until the next start.
- mode/target changes while RUN have no effect.
- busy is a registered state decode: 1 from the cycle after the s cycle through the stop cycle.
- Reset mid-RUN: outputs go to their reset values next cycle, and any pending window is lost.

Decomposition:
- Package window_match_pkg:
  - Mode constants MODE_EQ/GE/LE/NE.
  - State encoding ST_IDLE/ST_RUN.
  - Function for the compare.
- Sub-module window_match_chan, instantiated NCH times via generate:
  - One channel's accumulator, count register and z register.
  - Inputs: phase0, last, run, w bit, target_q, mode_q.
- The top holds the FSM, phase counter, latches and win_done.

Test Plan:
1. Legacy: WIN=3,NCH=1, target=2,mode=EQ; s pulse then w=1,1,0 | 1,0,1 | 1,1,1 -> z=1 in cycle after samples 3 and 6, z=0 after 9; count=2,2,3; win_done each time.
2. Modes: WIN=4, w=1,1,1,0 repeated, target=2 -> GE z=1, LE z=0, NE z=1, EQ z=0; target=7 with LE -> z=1.
3. Multichannel: NCH=4, WIN=3, target=1, EQ; per-window w[3:0] = 0001,0011,0101 -> counts ch0=3,ch1=1,ch2=1,ch3=0; z=4'b0110.
4. Stop: stop at phase 1 -> no win_done, busy drops, count unchanged; stop at phase WIN-1 -> pulse still issued next cycle, then IDLE; restart with s gives fresh phase 0.
5. Reset mid-window with w=1s, plus s during RUN and target changes during RUN -> ignored, no spurious z; after reset all outputs=0; first window after restart uses new latched target.
6. Random: 2000 cycles, random w/s/stop, WIN=5,NCH=3 vs reference model -> exact match of z/count/win_done/busy each cycle.
